// File: rtl/avr_bitio_pkg.sv
// Shared types for the bit-I/O read-modify-write sequencer.
//   bitio_st_t       : sequencer state (idle, bus read, bus write)
//   bitio_op_t       : latched bit-I/O instruction kind
//   IO_BITOP_ADR_MAX : highest I/O address reachable by SBI/CBI/SBIS/SBIC
//   op_pick          : fixed-priority selection among decoded ops
//   op_is_rmw        : ops that need a write-back phase
package avr_bitio_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} bitio_st_t;
  typedef enum logic [1:0] {OP_SBI, OP_CBI, OP_SBIS, OP_SBIC} bitio_op_t;

  localparam int IO_BITOP_ADR_MAX = 31;

  // sbi > cbi > sbis > sbic; caller guarantees at least one is set
  function automatic bitio_op_t op_pick(input logic sbi, input logic cbi,
                                        input logic sbis, input logic sbic);
    bitio_op_t op;
    op = OP_SBIC;
    if (sbi)       op = OP_SBI;
    else if (cbi)  op = OP_CBI;
    else if (sbis) op = OP_SBIS;
    else if (sbic) op = OP_SBIC;
    return op;
  endfunction

  function automatic logic op_is_rmw(input bitio_op_t op);
    return (op == OP_SBI) || (op == OP_CBI);
  endfunction

endpackage

// File: rtl/bit_io_tmo_cnt.sv
// Wait-state timeout counter for one bus phase.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (phase entry/exit), wins over inc
//   inc        : one qualified wait cycle in the current phase
//   expired    : this wait cycle is the TMO_CYC-th of the phase; 0 when TMO_CYC=0
module bit_io_tmo_cnt #(
  parameter int TMO_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                               cnt_d = '0;
    else if (inc && (cnt_q != CW'(TMO_CYC))) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Flag on the wait cycle that makes the count reach TMO_CYC so the abort
  // happens at that same edge rather than one cycle later.
  generate
    if (TMO_CYC == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = inc && (cnt_q >= CW'(TMO_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/bit_io_rmw_ctrl.sv
// Bit-I/O sequencer: read-modify-write for SBI/CBI, read-test for SBIS/SBIC.
//   cp2, ireset     : clock, synchronous active-low reset
//   cp2en           : clock enable, all state advances only when 1
//   idc_*           : decoded bit-I/O ops, sampled in IDLE
//   instr_adr/bit   : I/O address and bit number of the instruction
//   bit_test_op     : bit processor test result for SBIS/SBIC
//   bitpr_io_out    : bit processor modified byte for write-back
//   io_wait         : peripheral wait request
//   adr/iore/iowe/dbusout : I/O bus master side
//   bit_num_q       : latched bit number for the bit processor
//   sbi_st/cbi_st   : modify-phase indicators
//   core_stall      : holds the core while the op is in flight
//   skip_req/io_err : one-cycle pulses (skip next instr / timeout abort)
module bit_io_rmw_ctrl
  import avr_bitio_pkg::*;
#(
  parameter int IO_ADR_W = 6,
  parameter int TMO_CYC  = 16
) (
  input  logic                cp2,
  input  logic                ireset,
  input  logic                cp2en,
  input  logic                idc_sbi,
  input  logic                idc_cbi,
  input  logic                idc_sbis,
  input  logic                idc_sbic,
  input  logic [4:0]          instr_adr,
  input  logic [2:0]          instr_bit,
  input  logic                bit_test_op,
  input  logic [7:0]          bitpr_io_out,
  input  logic                io_wait,
  output logic [IO_ADR_W-1:0] adr,
  output logic                iore,
  output logic                iowe,
  output logic [7:0]          dbusout,
  output logic [2:0]          bit_num_q,
  output logic                sbi_st,
  output logic                cbi_st,
  output logic                core_stall,
  output logic                skip_req,
  output logic                io_err
);

  localparam int BA_W = $clog2(IO_BITOP_ADR_MAX + 1);

  bitio_st_t       st_q, st_d;
  bitio_op_t       op_q, op_d;
  logic [BA_W-1:0] adr_q, adr_d;
  logic [2:0]      bit_d;
  logic            skip_q, skip_d;
  logic            err_q, err_d;
  logic            any_idc;
  logic            tmo_clr, tmo_inc, tmo_exp;

  assign any_idc = idc_sbi | idc_cbi | idc_sbis | idc_sbic;

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      st_q      <= ST_IDLE;
      op_q      <= OP_SBI;
      adr_q     <= '0;
      bit_num_q <= '0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      op_q      <= op_d;
      adr_q     <= adr_d;
      bit_num_q <= bit_d;
      skip_q    <= skip_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    adr_d  = adr_q;
    bit_d  = bit_num_q;
    skip_d = skip_q;
    err_d  = err_q;
    // With cp2en=0 everything, including the pulse flops, holds.
    if (cp2en) begin
      skip_d = 1'b0;
      err_d  = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (any_idc) begin
            st_d  = ST_RD;
            op_d  = op_pick(idc_sbi, idc_cbi, idc_sbis, idc_sbic);
            adr_d = instr_adr;
            bit_d = instr_bit;
          end
        end
        ST_RD: begin
          if (tmo_exp) begin
            st_d  = ST_IDLE;
            err_d = 1'b1;
          end else if (!io_wait) begin
            if (op_is_rmw(op_q)) begin
              st_d = ST_WR;
            end else begin
              st_d   = ST_IDLE;
              skip_d = bit_test_op;
            end
          end
        end
        ST_WR: begin
          if (tmo_exp) begin
            st_d  = ST_IDLE;
            err_d = 1'b1;
          end else if (!io_wait) begin
            st_d = ST_IDLE;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  // Any state change is a phase boundary, which restarts the wait count.
  assign tmo_clr = cp2en && (st_d != st_q);
  assign tmo_inc = cp2en && io_wait && (st_q != ST_IDLE);

  bit_io_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk     (cp2),
    .rst_n   (ireset),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_exp)
  );

  assign iore       = (st_q == ST_RD);
  assign iowe       = (st_q == ST_WR);
  assign adr        = (iore || iowe) ? IO_ADR_W'(adr_q) : '0;
  assign dbusout    = iowe ? bitpr_io_out : 8'h00;
  assign sbi_st     = iowe && (op_q == OP_SBI);
  assign cbi_st     = iowe && (op_q == OP_CBI);
  // Stall already in the decode cycle so the PC does not move past the op.
  assign core_stall = (st_q != ST_IDLE) || any_idc;
  assign skip_req   = skip_q;
  assign io_err     = err_q;

endmodule
